// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and sync-window decode helper for the VGA demo path.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit VGA_H_POL = 1'b0;
    localparam bit VGA_V_POL = 1'b0;

    // True when pos lies in [lo, lo+len).
    function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N counter with enable; resets to N-1 so the first enabled edge lands on 0.
module vga_wrap_counter #(
    parameter int unsigned Width   = 10,
    parameter int unsigned Modulus = 800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] cnt_next_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] Last = Width'(Modulus - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= Last;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign wrap_o     = en_i && (cnt_q == Last);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: coordinates, syncs, active flag and line/frame strobes, all registered.
// Optional frame counter output enabled by defining VGA_SYNC_GEN_FRAME_CNT_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter bit          H_POL       = VGA_H_POL,
    parameter bit          V_POL       = VGA_V_POL,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    output logic [CNT_W-1:0]       hpos_o,
    output logic [CNT_W-1:0]       vpos_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   active_o,
    output logic                   line_start_o,
    output logic                   frame_start_o
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint unsigned CntRange = 64'd1 << CNT_W;

    if (H_TOTAL > CntRange || V_TOTAL > CntRange) begin : g_bad_cnt_w
        $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (FRAME_CNT_W == 0) begin : g_bad_frame_cnt_w
        $error("vga_sync_gen: FRAME_CNT_W must be non-zero");
    end

    logic [CNT_W-1:0] h_cnt, h_next, v_cnt, v_next;
    logic             h_wrap, v_wrap;

    vga_wrap_counter #(
        .Width  (CNT_W),
        .Modulus(H_TOTAL)
    ) u_h_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .cnt_o     (h_cnt),
        .cnt_next_o(h_next),
        .wrap_o    (h_wrap)
    );

    vga_wrap_counter #(
        .Width  (CNT_W),
        .Modulus(V_TOTAL)
    ) u_v_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (h_wrap),
        .cnt_o     (v_cnt),
        .cnt_next_o(v_next),
        .wrap_o    (v_wrap)
    );

    logic hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;

    // Decode from the next-state counters so every output matches the coordinates it sits beside.
    always_comb begin
        hsync_d       = in_window(32'(h_next), H_ACTIVE + H_FP, H_SYNC) ? H_POL : ~H_POL;
        vsync_d       = in_window(32'(v_next), V_ACTIVE + V_FP, V_SYNC) ? V_POL : ~V_POL;
        active_d      = (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos_o        = h_cnt;
    assign vpos_o        = v_cnt;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign active_o      = active_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // All-ones reset so the frame that starts right after reset reads 0.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: directed table, multi-cycle sequences and randomized en/reset vs a model.
module tb_vga_sync_gen;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VA = 20, VFP = 3, VS = 2, VBP = 5;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int CW = 10;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] hpos, vpos;
    logic          hsync, vsync, active, line_start, frame_start;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    logic [FW-1:0] frame_cnt;
`endif

    vga_sync_gen #(
        .CNT_W      (CW),
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HS),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .H_POL      (1'b0),
        .V_POL      (1'b0),
        .FRAME_CNT_W(FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .hpos_o       (hpos),
        .vpos_o       (vpos),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .active_o     (active),
        .line_start_o (line_start),
        .frame_start_o(frame_start)
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        ,
        .frame_cnt_o  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: raster position, strobes and frame number.
    int mh = HT - 1;
    int mv = VT - 1;
    bit mls = 1'b0;
    bit mfs = 1'b0;
    int mfc = (1 << FW) - 1;

    function automatic bit exp_hsync(input int h);
        return !(h >= HA + HFP && h < HA + HFP + HS);
    endfunction

    function automatic bit exp_vsync(input int v);
        return !(v >= VA + VFP && v < VA + VFP + VS);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Advance the model on the current inputs, clock the DUT, then compare all outputs.
    task automatic step();
        bit bad;
        if (!rst_n) begin
            mh = HT - 1; mv = VT - 1; mls = 0; mfs = 0; mfc = (1 << FW) - 1;
        end else if (en) begin
            mh = (mh + 1) % HT;
            if (mh == 0) mv = (mv + 1) % VT;
            mls = (mh == 0);
            mfs = (mh == 0) && (mv == 0);
            if (mfs) mfc = (mfc + 1) % (1 << FW);
        end else begin
            mls = 0; mfs = 0;
        end
        @(posedge clk);
        #1;
        bad = (int'(hpos) != mh) || (int'(vpos) != mv) || (hsync !== exp_hsync(mh)) ||
              (vsync !== exp_vsync(mv)) || (active !== (mh < HA && mv < VA)) ||
              (line_start !== mls) || (frame_start !== mfs);
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        bad = bad || (int'(frame_cnt) != mfc);
`endif
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL model: got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b, expected h=%0d v=%0d ls=%b fs=%b",
                     hpos, vpos, hsync, vsync, active, line_start, frame_start, mh, mv, mls, mfs);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".hpos"}, int'(hpos), HT - 1);
        chk({nm, ".vpos"}, int'(vpos), VT - 1);
        chk({nm, ".hsync"}, int'(hsync), 1);
        chk({nm, ".vsync"}, int'(vsync), 1);
        chk({nm, ".active"}, int'(active), 0);
        chk({nm, ".line_start"}, int'(line_start), 0);
        chk({nm, ".frame_start"}, int'(frame_start), 0);
    endtask

    typedef struct {
        int n;
        int hp;
        int vp;
        bit hs;
        bit vs;
        bit act;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int vs_low;
        int fs_seen;
        int ls_seen;

        tbl.push_back('{1,     0,   0,  1, 1, 1, 1, 1});
        tbl.push_back('{1,     1,   0,  1, 1, 1, 0, 0});
        tbl.push_back('{638,   639, 0,  1, 1, 1, 0, 0});
        tbl.push_back('{1,     640, 0,  1, 1, 0, 0, 0});
        tbl.push_back('{15,    655, 0,  1, 1, 0, 0, 0});
        tbl.push_back('{1,     656, 0,  0, 1, 0, 0, 0});
        tbl.push_back('{95,    751, 0,  0, 1, 0, 0, 0});
        tbl.push_back('{1,     752, 0,  1, 1, 0, 0, 0});
        tbl.push_back('{47,    799, 0,  1, 1, 0, 0, 0});
        tbl.push_back('{1,     0,   1,  1, 1, 1, 1, 0});
        tbl.push_back('{17599, 799, 22, 1, 1, 0, 0, 0});
        tbl.push_back('{1,     0,   23, 1, 0, 0, 1, 0});

        // Reset held with en=1: reset must win.
        rst_n = 1'b0; en = 1'b1;
        repeat (3) step();
        chk_reset_state("reset");

        // First frame: count vsync-low cycles and frame strobes over exactly one frame.
        rst_n = 1'b1;
        step();
        chk("first.hpos", int'(hpos), 0);
        chk("first.frame_start", int'(frame_start), 1);
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        chk("first.frame_cnt", int'(frame_cnt), 0);
`endif
        vs_low = (vsync == 1'b0) ? 1 : 0;
        fs_seen = 0;
        for (int i = 0; i < HT * VT; i++) begin
            step();
            if (i < HT * VT - 1 && vsync == 1'b0) vs_low++;
            if (frame_start) fs_seen++;
        end
        chk("frame.vsync_low_cycles", vs_low, VS * HT);
        chk("frame.frame_starts", fs_seen, 1);
        chk("frame.wrap_hpos", int'(hpos), 0);
        chk("frame.wrap_vpos", int'(vpos), 0);
        chk("frame.wrap_frame_start", int'(frame_start), 1);
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        chk("frame.frame_cnt", int'(frame_cnt), 1);
`endif

        // Directed table from a fresh reset.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1; en = 1'b1;
        foreach (tbl[i]) begin
            repeat (tbl[i].n) step();
            chk($sformatf("tbl%0d.hpos", i), int'(hpos), tbl[i].hp);
            chk($sformatf("tbl%0d.vpos", i), int'(vpos), tbl[i].vp);
            chk($sformatf("tbl%0d.hsync", i), int'(hsync), int'(tbl[i].hs));
            chk($sformatf("tbl%0d.vsync", i), int'(vsync), int'(tbl[i].vs));
            chk($sformatf("tbl%0d.active", i), int'(active), int'(tbl[i].act));
            chk($sformatf("tbl%0d.line_start", i), int'(line_start), int'(tbl[i].ls));
            chk($sformatf("tbl%0d.frame_start", i), int'(frame_start), int'(tbl[i].fs));
        end

        // en gating at the end of line 23 (inside vsync).
        repeat (HT - 1) step();
        chk("gate.pre_hpos", int'(hpos), HT - 1);
        en = 1'b0;
        ls_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (line_start) ls_seen++;
            chk($sformatf("gate%0d.hpos", i), int'(hpos), HT - 1);
            chk($sformatf("gate%0d.vpos", i), int'(vpos), 23);
            chk($sformatf("gate%0d.vsync", i), int'(vsync), 0);
            chk($sformatf("gate%0d.hsync", i), int'(hsync), 1);
        end
        chk("gate.hold_line_starts", ls_seen, 0);
        en = 1'b1;
        step();
        chk("gate.resume_hpos", int'(hpos), 0);
        chk("gate.resume_vpos", int'(vpos), 24);
        chk("gate.resume_line_start", int'(line_start), 1);
        step();
        chk("gate.after_line_start", int'(line_start), 0);

        // Mid-frame reset with en=1.
        repeat (3 * HT + 122) step();
        chk("mid.hpos", int'(hpos), 123);
        chk("mid.vpos", int'(vpos), 27);
        rst_n = 1'b0;
        step();
        chk_reset_state("mid_reset");
        rst_n = 1'b1;
        step();
        chk("mid_release.hpos", int'(hpos), 0);
        chk("mid_release.vpos", int'(vpos), 0);
        chk("mid_release.frame_start", int'(frame_start), 1);
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        chk("mid_release.frame_cnt", int'(frame_cnt), 0);
`endif

        // Randomized en and occasional reset against the model.
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing source for the VGA demo path.
- Generates pixel coordinates, hsync/vsync, an active-video flag, and line/frame strobes.
- These drive the pattern generator, and through it the dither/output stage's vsync-edge frame counting.
- All outputs are registered and mutually aligned: every output in a given cycle describes the same pixel.

Parameters:
- CNT_W, 10: width of hpos/vpos counters.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: hsync pulse width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vsync pulse width in lines.
- V_BP, 33: vertical back porch.
- H_POL, 0: hsync asserted level (0 = active-low).
- V_POL, 0: vsync asserted level (0 = active-low).
- FRAME_CNT_W, 8: frame counter width (used only with the optional feature).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- en  in  1  pixel advance enable; state holds when 0
- hpos  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- vpos  out  CNT_W  current vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at H_POL polarity
- vsync  out  1  vertical sync at V_POL polarity
- active  out  1  1 when hpos<H_ACTIVE and vpos<V_ACTIVE
- line_start  out  1  one-cycle pulse when hpos becomes 0
- frame_start  out  1  one-cycle pulse when (hpos,vpos) becomes (0,0)
- frame_cnt  out  FRAME_CNT_W  present only with VGA_SYNC_GEN_FRAME_CNT_EN

Behaviour:
- Reset is decided: rst_n, synchronous, active-low; clock clk.
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset state (rst_n=0 at a clk edge):
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1.
  - active=0, line_start=0, frame_start=0.
  - hsync=~H_POL, vsync=~V_POL.
  - This places the generator on the last pixel, so the first enabled cycle after reset presents (0,0).
- Advance, on an edge with en=1:
  - hpos wraps H_TOTAL-1 -> 0, otherwise increments.
  - vpos increments only when hpos wraps; vpos wraps V_TOTAL-1 -> 0.
- Hold, on an edge with en=0:
  - hpos, vpos, hsync, vsync and active hold.
  - line_start and frame_start clear to 0.
- Registered outputs are computed from the next-state counters, giving zero latency between coordinates and decode:
  - hsync asserted iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - vsync asserted iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
  - vsync changes only on the cycle where hpos becomes 0.
  - line_start = 1 iff this edge advanced and the new hpos is 0.
  - frame_start = 1 iff this edge advanced and the new (hpos,vpos) is (0,0).
- Compare arithmetic is unsigned at CNT_W bits. H_TOTAL and V_TOTAL must fit in CNT_W (elaboration-time check; fail on violation).
- Reset mid-frame: the next edge returns to the reset state regardless of en; no partial strobes.
- rst_n and en both asserted: reset wins.

Optional Feature:
- Macro: VGA_SYNC_GEN_FRAME_CNT_EN.
- Defined:
  - frame_cnt port exists.
  - Reset value all-ones, so the first frame after reset reads 0.
  - Increments on the same edge that sets frame_start; wraps modulo 2^FRAME_CNT_W.
  - Holds when en=0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 constants (H_ACTIVE..V_BP).
  - Derived H_TOTAL/V_TOTAL.
  - Default polarities.
  - The parameter defaults reference it.
- Sub-module vga_wrap_counter is natural: a parameterised modulo-N counter with enable, a wrap output, and a reset-to-(N-1) value. It is instantiated twice: horizontal enabled by en; vertical enabled by en and the horizontal wrap.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles.
  - Required: hpos=799, vpos=524, active=0, hsync=1, vsync=1, strobes 0.
- First enabled edge after release:
  - Required: hpos=0, vpos=0, active=1, line_start=1, frame_start=1, frame_cnt=0 (macro defined).
  - Next edge: both strobes 0, hpos=1.
- hsync window, en held 1 on line 0:
  - hsync=1 at hpos=655, 0 from 656 through 751, 1 at 752.
  - active falls at hpos=640.
  - At 799->0: vpos=1, line_start=1, frame_start=0.
- vsync and frame wrap, run a full frame:
  - vsync=0 exactly for vpos 490..491, i.e. 1600 cycles.
  - After 420000 enabled cycles: back at (0,0), frame_start=1, frame_cnt=1.
- en gating, toggle en=0 for 5 cycles at hpos=799:
  - hpos/vpos/syncs hold.
  - On resume, one edge gives hpos=0 with line_start=1, with no duplicate pulse during the hold.
- Mid-frame reset at vpos=300, hpos=123 with en=1:
  - Next edge gives the reset state.
  - After release: (0,0) with frame_start=1, frame_cnt=0.
